// File: rtl/display_pkg.sv
// Shared constants, scan-state encoding and anode polarity helper for the
// multiplexed 7-segment display scanner.
package display_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    // Electrical level for one anode given its logical enable.
    function automatic logic anode_level(input logic on, input bit active_low);
        return active_low ? ~on : on;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot counter: runs 0..PRESCALE-1 while enabled, held at 0 otherwise,
// with strobes for the last dead-time cycle and the end of the slot.
module scan_prescaler #(
    parameter int unsigned PRESCALE  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tc,
    output logic blank_end
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        tc        = (cnt == CW'(PRESCALE - 1));
        blank_end = (cnt == CW'(BLANK_CYC - 1));
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller: shadows the multi-digit value, steps a
// one-hot anode through the digits with dead time and leading-zero blanking.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DIGITS           = 4,
    parameter int unsigned PRESCALE         = 50000,
    parameter int unsigned BLANK_CYC        = 16,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [DIGIT_W*DIGITS-1:0]   value,
    input  logic                        load,
    input  logic [DIGITS-1:0]           dp_mask,
    input  logic                        lz_blank,
    output logic [DIGIT_W-1:0]          dig_val,
    output logic [DIGITS-1:0]           anode,
    output logic                        dp,
    output logic                        seg_blank,
    output logic                        load_ack,
    output logic                        frame_tick
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = DIGIT_W * DIGITS;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    scan_state_t        state;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      idx_inc;
    logic [IW-1:0]      entry_idx;
    logic [VW-1:0]      disp;
    logic [VW-1:0]      pend;
    logic [VW-1:0]      src_val;
    logic [VW-1:0]      new_disp;
    logic [DIGITS-1:0]  disp_dp;
    logic [DIGITS-1:0]  pend_dp;
    logic [DIGITS-1:0]  src_dp;
    logic [DIGITS-1:0]  new_dp;
    logic [DIGITS-1:0]  anode_off;
    logic [DIGITS-1:0]  anode_sel;
    logic [DIGIT_W-1:0] entry_nib;
    logic               entry_dp;
    logic               entry_blank;
    logic               pend_valid;
    logic               run;
    logic               tc;
    logic               blank_end;
    logic               boundary;
    logic               do_xfer;

    assign run = en && (state != IDLE);

    scan_prescaler #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .tc        (tc),
        .blank_end (blank_end)
    );

    // Digit attributes are latched on BLANK entry from the display value that
    // will hold for the coming slot, so a frame-boundary transfer is seen at once.
    always_comb begin
        idx_inc   = (idx == LAST) ? '0 : idx + 1'b1;
        entry_idx = (state == IDLE) ? '0 : idx_inc;
        boundary  = en && ((state == IDLE) || ((state == SHOW) && tc && (idx == LAST)));
        src_val   = load ? value : pend;
        src_dp    = load ? dp_mask : pend_dp;
        do_xfer   = boundary && (load || pend_valid);
        new_disp  = do_xfer ? src_val : disp;
        new_dp    = do_xfer ? src_dp : disp_dp;
        entry_nib   = new_disp[DIGIT_W*entry_idx +: DIGIT_W];
        entry_dp    = new_dp[entry_idx];
        entry_blank = lz_blank && (entry_idx != '0)
                      && ((new_disp >> (DIGIT_W*entry_idx)) == '0);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            anode_off[i] = anode_level(1'b0, ANODE_ACTIVE_LOW);
            anode_sel[i] = anode_level(idx == IW'(i), ANODE_ACTIVE_LOW);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            disp       <= '0;
            disp_dp    <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            anode      <= {DIGITS{ANODE_ACTIVE_LOW}};
            dig_val    <= '0;
            dp         <= 1'b0;
            seg_blank  <= 1'b1;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;

            if (!en) begin
                state     <= IDLE;
                idx       <= '0;
                anode     <= anode_off;
                dig_val   <= '0;
                dp        <= 1'b0;
                seg_blank <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= BLANK;
                        idx       <= '0;
                        dig_val   <= entry_nib;
                        dp        <= entry_dp;
                        seg_blank <= entry_blank;
                    end
                    BLANK: begin
                        if (blank_end) begin
                            state <= SHOW;
                            anode <= anode_sel;
                        end
                    end
                    SHOW: begin
                        if (tc) begin
                            state      <= BLANK;
                            idx        <= idx_inc;
                            anode      <= anode_off;
                            dig_val    <= entry_nib;
                            dp         <= entry_dp;
                            seg_blank  <= entry_blank;
                            frame_tick <= (idx == LAST);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (do_xfer) begin
                disp       <= src_val;
                disp_dp    <= src_dp;
                pend_valid <= 1'b0;
                load_ack   <= 1'b1;
            end else if (load) begin
                pend       <= value;
                pend_dp    <= dp_mask;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl against a timing-arithmetic model
// (slot = t / PRESCALE, position = t % PRESCALE since the first BLANK entry).
module tb_display_scan_ctrl;

    localparam int unsigned D  = 4;
    localparam int unsigned P  = 8;
    localparam int unsigned B  = 2;
    localparam int unsigned FR = P * D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  dig_val;
    logic [3:0]  anode;
    logic        dp;
    logic        seg_blank;
    logic        load_ack;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          running = 1'b0;
    bit          fresh = 1'b1;
    int unsigned t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_dpd = '0;
    logic [3:0]  m_dpp = '0;
    bit          m_pv = 1'b0;

    display_scan_ctrl #(
        .DIGITS           (D),
        .PRESCALE         (P),
        .BLANK_CYC        (B),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .value      (value),
        .load       (load),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .dig_val    (dig_val),
        .anode      (anode),
        .dp         (dp),
        .seg_blank  (seg_blank),
        .load_ack   (load_ack),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic int unsigned cur_slot();
        return (t / P) % D;
    endfunction

    function automatic int unsigned cur_pos();
        return t % P;
    endfunction

    task automatic model_reset();
        running = 1'b0;
        fresh   = 1'b1;
        t       = 0;
        m_disp  = '0;
        m_pend  = '0;
        m_dpd   = '0;
        m_dpp   = '0;
        m_pv    = 1'b0;
    endtask

    task automatic check_idle();
        check("idle_anode", 32'(anode), 32'hF);
        if (fresh) begin
            check("idle_dig", 32'(dig_val), 32'h0);
            check("idle_dp", 32'(dp), 32'h0);
            check("idle_blank", 32'(seg_blank), 32'h1);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, check outputs.
    task automatic step(input bit e, input bit ld, input logic [15:0] v, input logic [3:0] m);
        bit          bnd;
        bit          exp_ack;
        bit          exp_tick;
        int unsigned s;
        int unsigned p;
        logic [3:0]  ea;
        en      = e;
        load    = ld;
        value   = v;
        dp_mask = m;
        @(posedge clk);
        bnd      = 1'b0;
        exp_ack  = 1'b0;
        exp_tick = 1'b0;
        if (!e) begin
            running = 1'b0;
            t       = 0;
        end else if (!running) begin
            running = 1'b1;
            fresh   = 1'b0;
            t       = 0;
            bnd     = 1'b1;
        end else begin
            t++;
            if (t % FR == 0) begin
                bnd      = 1'b1;
                exp_tick = 1'b1;
            end
        end
        if (bnd && (ld || m_pv)) begin
            m_disp  = ld ? v : m_pend;
            m_dpd   = ld ? m : m_dpp;
            m_pv    = 1'b0;
            exp_ack = 1'b1;
        end else if (ld) begin
            m_pend = v;
            m_dpp  = m;
            m_pv   = 1'b1;
        end
        #1;
        load = 1'b0;
        check("load_ack", 32'(load_ack), 32'(exp_ack));
        check("frame_tick", 32'(frame_tick), 32'(exp_tick));
        if (running) begin
            s  = cur_slot();
            p  = cur_pos();
            ea = (p >= B) ? ~(4'b0001 << s) : 4'hF;
            check("anode", 32'(anode), 32'(ea));
            if (p >= B - 1) begin
                check("dig_val", 32'(dig_val), 32'(m_disp[s*4 +: 4]));
                check("dp", 32'(dp), 32'(m_dpd[s]));
                check("seg_blank", 32'(seg_blank),
                      32'(lz_blank && (s != 0) && ((m_disp >> (4*s)) == 16'h0)));
            end
        end else begin
            check_idle();
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    endtask

    // Advance until the SHOW phase of the given digit, with a cycle budget.
    task automatic run_to_show(input int unsigned s);
        int unsigned k = 0;
        while (!(running && cur_slot() == s && cur_pos() >= B) && k < 3 * FR) begin
            step(1'b1, 1'b0, 16'h0, 4'h0);
            k++;
        end
        if (k >= 3 * FR) check("run_to_show_budget", 32'(k), 32'(3 * FR - 1));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #12;
        check("rst_anode", 32'(anode), 32'hF);
        check("rst_blank", 32'(seg_blank), 32'h1);
        check("rst_dig", 32'(dig_val), 32'h0);
        check("rst_ack", 32'(load_ack), 32'h0);
        check("rst_tick", 32'(frame_tick), 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // 1: load 1234 while idle, then scan two frames
        step(1'b0, 1'b1, 16'h1234, 4'b0010);
        run(2 * FR + 4);

        // 2: mid-frame load during digit 1
        run_to_show(1);
        step(1'b1, 1'b1, 16'hABCD, 4'b1000);
        run(2 * FR);

        // 3: two loads in one frame, one ack
        run_to_show(1);
        step(1'b1, 1'b1, 16'h1111, 4'h0);
        run_to_show(2);
        step(1'b1, 1'b1, 16'h2222, 4'h0);
        run(2 * FR);

        // 4: leading-zero blanking (lz changed only while stopped)
        step(1'b0, 1'b1, 16'h0050, 4'b0100);
        lz_blank = 1'b1;
        run(FR + 2);
        step(1'b1, 1'b1, 16'h0000, 4'b1001);
        run(2 * FR);

        // 5: en dropped during SHOW of digit 2, then restart at digit 0
        run_to_show(2);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        run(FR + 3);

        // Randomized traffic with occasional enable drops and lz changes
        lz_blank = 1'b0;
        for (int unsigned i = 0; i < 900; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                for (int unsigned j = 0; j < $urandom_range(1, 4); j++) begin
                    if ($urandom_range(0, 1) == 1) lz_blank = ~lz_blank;
                    step(1'b0, ($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom));
                end
            end else begin
                step(1'b1, ($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom));
            end
        end

        // 6: asynchronous reset mid-SHOW, no clock edge needed
        run_to_show(1);
        #2 rst = 1'b1;
        #1;
        check("arst_anode", 32'(anode), 32'hF);
        check("arst_blank", 32'(seg_blank), 32'h1);
        check("arst_ack", 32'(load_ack), 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
        run(FR + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
